// File: rtl/aes_pkg.sv
// Shared AES definitions: key-schedule state encoding, word width, Rcon seed
// and the GF(2^8) doubling used by both the key schedule and MixColumns.
package aes_pkg;

    localparam int         WORD_W    = 32;
    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        MIX  = 2'd2
    } ks_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_key_sched_iter_s4.sv
// Registered 4-byte AES S-box (SubWord), one cycle of latency.
module aes_key_sched_iter_s4
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Pure datapath register: no reset, the FSM never consumes it before a SUB cycle fills it.
    for (genvar g = 0; g < WORD_W / 8; g++) begin : g_byte
        always_ff @(posedge clk) begin
            dout[8*g +: 8] <= SBOX[din[8*g +: 8]];
        end
    end

endmodule

// File: rtl/aes_key_sched_iter.sv
// Iterative AES-128 key expansion: emits round keys 0..NUM_ROUNDS, one every
// two cycles (SUB registers SubWord(RotWord(w3)), MIX folds it into the key).
module aes_key_sched_iter
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         done,
    output logic         busy
);

    ks_state_t         state, state_d;
    logic [127:0]      key_d;
    logic [3:0]        idx_d;
    logic              kv_d, done_d, last;
    logic [7:0]        rcon, rcon_d;
    logic [WORD_W-1:0] w0, w1, w2, w3, sub_q, t, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = round_key;

    aes_key_sched_iter_s4 u_s4 (
        .clk  (clk),
        .din  ({w3[23:0], w3[31:24]}),
        .dout (sub_q)
    );

    assign t  = sub_q ^ {rcon, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign last = (round_idx + 4'd1) == 4'(NUM_ROUNDS);
    assign busy = (state != IDLE);

    always_comb begin
        state_d = state;
        key_d   = round_key;
        idx_d   = round_idx;
        kv_d    = 1'b0;
        done_d  = 1'b0;
        rcon_d  = rcon;
        case (state)
            IDLE: if (start) begin
                key_d   = key_in;
                idx_d   = 4'd0;
                kv_d    = 1'b1;
                rcon_d  = RCON_INIT;
                state_d = SUB;
            end
            SUB: state_d = MIX;
            MIX: begin
                key_d   = {n0, n1, n2, n3};
                idx_d   = round_idx + 4'd1;
                kv_d    = 1'b1;
                rcon_d  = xtime(rcon);
                done_d  = last;
                state_d = last ? IDLE : SUB;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            round_key <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            done      <= 1'b0;
            rcon      <= RCON_INIT;
        end else begin
            state     <= state_d;
            round_key <= key_d;
            round_idx <= idx_d;
            key_valid <= kv_d;
            done      <= done_d;
            rcon      <= rcon_d;
        end
    end

endmodule
